secded_stream_decoder: RTL and testbench
========================================

# secded_stream_decoder

Parametrised, pipelined SECDED (extended Hamming) decoder with a valid/ready stream interface and saturating error-statistics counters. Generalises the fixed 16-bit (15,11) detect/correct path to any data width. It sits between a storage or link read port and the consumer: it corrects single-bit errors, flags double-bit errors and counts both.

## Interface
- DATA_W, 11, data bits per codeword.
- PAR_W, derived, smallest r with 2^r >= DATA_W + r + 1 (4 for DATA_W=11); localparam.
- CODE_W, derived, DATA_W + PAR_W + 1 (16 for DATA_W=11); localparam.
- CNT_W, 16, width of each error counter.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream codeword valid.
- in_ready  output  1  decoder can accept a codeword this cycle.
- in_code  input  CODE_W  received codeword.
- out_valid  output  1  decoded word valid.
- out_ready  input  1  downstream accepts the decoded word.
- out_data  output  DATA_W  corrected data.
- out_sed  output  1  single error detected and corrected.
- out_ded  output  1  uncorrectable (double) error detected.
- cnt_clr  input  1  synchronous clear of both counters.
- cnt_sec  output  CNT_W  count of delivered words with out_sed=1.
- cnt_ded  output  CNT_W  count of delivered words with out_ded=1.
- inj_mask  input  CODE_W  error-injection mask (present only with SECDED_INJECT_EN).

## Operation
- Codeword layout: bit 0 is the overall even parity over all CODE_W bits. Bits 1..CODE_W-1 form a Hamming code. Parity bits sit at the power-of-two positions. Data bits fill the remaining positions in ascending order, data LSB at position 3.
- Stage 1, on accept (in_valid && in_ready): register the codeword, syndrome s (PAR_W bits; XOR of the indices of the set bits in 1..CODE_W-1) and overall parity p.
- Stage 2 classifies the word:
  - s=0, p=0: clean; sed=0, ded=0.
  - p=1, s<=CODE_W-1: flip bit s (s=0 means bit 0 is flipped, data unaffected); sed=1, ded=0.
  - p=0, s!=0: double error; ded=1, sed=0; data passed through uncorrected.
  - p=1, s>CODE_W-1 (only possible for shortened codes): ded=1, sed=0, uncorrected.
- Data is extracted from the (corrected) codeword into out_data and registered together with the flags.
- Counters:
  - Each counts only on output transfer (out_valid && out_ready) with its flag set; saturates at all-ones.
  - cnt_clr forces 0 and wins over a same-cycle increment.

## Timing
- Two-stage pipeline; latency is 2 cycles from accept to out_valid. Throughput is 1 word per cycle with out_ready held high.
- Handshake: s2_load = !out_valid || out_ready; s1_load = !s1_valid || s2_load; in_ready = s1_load. in_ready is registered-path only; there is no combinational in_valid-to-in_ready path.
- While out_valid=1 and out_ready=0, out_data/out_sed/out_ded hold stable. Words are never dropped, duplicated or reordered.
- Maximum in-flight is 2 words. With out_ready low, in_ready drops once both stages are full.
- Reset values: out_valid=0, out_data=0, out_sed=0, out_ded=0, cnt_sec=0, cnt_ded=0, internal valids=0; in_ready=1 after reset.
- Reset asserted mid-stream discards in-flight words immediately (asynchronous) and clears the counters.
- Counters update one cycle after the transfer edge.

## Configuration
- SECDED_INJECT_EN defined: the inj_mask port exists. On accept, in_code ^ inj_mask is captured into stage 1. Intended for bench and field fault injection.
- SECDED_INJECT_EN undefined: the port is absent and in_code is captured unmodified; no injection logic is synthesised.

## Test plan
- Reset: assert rst for 3 cycles with in_valid=1 -> out_valid=0, cnt_sec=cnt_ded=0, in_ready=1 on release.
- Clean word: golden encoding of data 11'h18E, out_ready=1 -> 2 cycles later out_data=11'h18E, out_sed=0, out_ded=0; counters unchanged.
- Single error: same codeword with bit 2 flipped (then separately bit 0, then bit 15) -> out_data=11'h18E, out_sed=1, out_ded=0; cnt_sec increments to 1, 2, 3.
- Double error: codeword ^ 16'h000C -> out_ded=1, out_sed=0, out_data equals the uncorrected extraction; cnt_ded=1.
- Backpressure:
  - Offer 4 distinct words back-to-back with out_ready=0 for 6 cycles -> exactly 2 accepted, in_ready=0 thereafter, out_data stable.
  - Then raise out_ready -> all 4 delivered in order, no gaps once streaming.
- Counter saturation/clear with CNT_W=2 -> 5 single errors give cnt_sec=3; cnt_clr in the same cycle as a sed transfer gives cnt_sec=0. With SECDED_INJECT_EN, inj_mask=16'h0004 on a clean word gives out_sed=1.

Source files
------------

// File: rtl/secded_stream_decoder.sv
// secded_stream_decoder: pipelined SECDED decoder with a valid/ready stream and saturating error counters.
// Optional fault injection on the input is compiled in with SECDED_INJECT_EN.
module secded_stream_decoder #(
    parameter int DATA_W = 11,
    parameter int CNT_W = 16,
    localparam int PAR_W = (DATA_W <= 1) ? 2 : (DATA_W <= 4) ? 3 : (DATA_W <= 11) ? 4 :
                           (DATA_W <= 26) ? 5 : (DATA_W <= 57) ? 6 : (DATA_W <= 120) ? 7 : 8,
    localparam int CODE_W = DATA_W + PAR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sed,
    output logic              out_ded,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  cnt_sec,
    output logic [CNT_W-1:0]  cnt_ded
`ifdef SECDED_INJECT_EN
   ,input  logic [CODE_W-1:0] inj_mask
`endif
);

    // XOR of the indices of all set bits in the Hamming part of the codeword
    function automatic logic [PAR_W-1:0] syndrome(input logic [CODE_W-1:0] c);
        logic [PAR_W-1:0] s;
        s = '0;
        for (int i = 1; i < CODE_W; i++)
            if (c[i]) s = s ^ PAR_W'(i);
        return s;
    endfunction

    // data bits occupy the non-power-of-two positions, shifted in so the lowest lands at bit 0
    function automatic logic [DATA_W-1:0] extract(input logic [CODE_W-1:0] c);
        logic [DATA_W-1:0] d;
        d = '0;
        for (int i = 3; i < CODE_W; i++)
            if ((i & (i - 1)) != 0) d = (d >> 1) | (DATA_W'(c[i]) << (DATA_W - 1));
        return d;
    endfunction

    logic              s1_valid;
    logic [CODE_W-1:0] s1_code;
    logic [PAR_W-1:0]  s1_syn;
    logic              s1_par;
    logic [CODE_W-1:0] cap;
    logic [CODE_W-1:0] corr;
    logic              fits;
    logic              sed;
    logic              ded;
    logic              s1_load;
    logic              s2_load;
    logic              xfer;

`ifdef SECDED_INJECT_EN
    assign cap = in_code ^ inj_mask;
`else
    assign cap = in_code;
`endif

    assign s2_load  = !out_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;
    assign xfer     = out_valid && out_ready;

    // classify the staged word and flip the erroneous bit when it is correctable
    always_comb begin
        fits = 32'(s1_syn) < CODE_W;
        sed  = s1_par && fits;
        ded  = s1_par ? !fits : (s1_syn != '0);
        corr = sed ? s1_code ^ (CODE_W'(1) << s1_syn) : s1_code;
    end

    // stage 1: capture codeword with its syndrome and overall parity
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_code  <= '0;
            s1_syn   <= '0;
            s1_par   <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            s1_code  <= cap;
            s1_syn   <= syndrome(cap);
            s1_par   <= ^cap;
        end
    end

    // stage 2: register corrected data and flags, holding them under backpressure
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sed   <= 1'b0;
            out_ded   <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            out_data  <= extract(corr);
            out_sed   <= s1_valid && sed;
            out_ded   <= s1_valid && ded;
        end
    end

    // saturating error counters bumped on delivered words; clear has priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_sec <= '0;
            cnt_ded <= '0;
        end else begin
            cnt_sec <= cnt_clr ? '0 : (xfer && out_sed && cnt_sec != '1) ? cnt_sec + CNT_W'(1) : cnt_sec;
            cnt_ded <= cnt_clr ? '0 : (xfer && out_ded && cnt_ded != '1) ? cnt_ded + CNT_W'(1) : cnt_ded;
        end
    end

endmodule

// File: tb/tb_secded_stream_decoder.sv
// tb_secded_stream_decoder: directed vector bench for the SECDED stream decoder (default and 2-bit counters).
module tb_secded_stream_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        cnt_clr = 1'b0;
    logic [15:0] in_code = '0;
    logic        in_ready, out_valid, out_sed, out_ded;
    logic [10:0] out_data;
    logic [15:0] cnt_sec, cnt_ded;
    logic        in_ready_n, out_valid_n, out_sed_n, out_ded_n;
    logic [10:0] out_data_n;
    logic [1:0]  cnt_sec_n, cnt_ded_n;
`ifdef SECDED_INJECT_EN
    logic [15:0] inj_mask = '0;
`endif

    secded_stream_decoder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sed(out_sed),
        .out_ded(out_ded), .cnt_clr(cnt_clr), .cnt_sec(cnt_sec), .cnt_ded(cnt_ded)
`ifdef SECDED_INJECT_EN
       ,.inj_mask(inj_mask)
`endif
    );

    secded_stream_decoder #(.CNT_W(2)) dut_n (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_n), .in_code(in_code),
        .out_valid(out_valid_n), .out_ready(out_ready), .out_data(out_data_n), .out_sed(out_sed_n),
        .out_ded(out_ded_n), .cnt_clr(cnt_clr), .cnt_sec(cnt_sec_n), .cnt_ded(cnt_ded_n)
`ifdef SECDED_INJECT_EN
       ,.inj_mask(inj_mask)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] code;
        logic [10:0] data;
        logic        sed;
        logic        ded;
    } vec_t;

    vec_t tbl[13];
    int   n_chk = 0;
    int   n_bad = 0;
    int   exp_sec = 0;
    int   exp_ded = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_counts(input string nm);
        chk({nm, " cnt_sec"}, cnt_sec, exp_sec);
        chk({nm, " cnt_ded"}, cnt_ded, exp_ded);
        chk({nm, " cnt_sec sat"}, cnt_sec_n, exp_sec > 3 ? 3 : exp_sec);
        chk({nm, " cnt_ded sat"}, cnt_ded_n, exp_ded > 3 ? 3 : exp_ded);
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int n = 0;
        in_valid = 1'b1;
        in_code  = v.code;
        step();
        in_valid = 1'b0;
        while (!out_valid && n < 8) begin
            step();
            n++;
        end
        chk({nm, " latency"}, n, 1);
        chk({nm, " data"}, out_data, v.data);
        chk({nm, " sed"}, out_sed, v.sed);
        chk({nm, " ded"}, out_ded, v.ded);
        chk({nm, " data n"}, out_data_n, v.data);
        step();
        if (v.sed) exp_sec++;
        if (v.ded) exp_ded++;
        chk({nm, " no dup"}, out_valid, 0);
        chk_counts(nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] w[4];
        logic [10:0] wd[4];
        logic [10:0] held;
        vec_t        v;
        int          idx, got, last, gaps;
        logic        acc;

        tbl[0]  = '{16'h30F3, 11'h18E, 1'b0, 1'b0};
        tbl[1]  = '{16'h30F7, 11'h18E, 1'b1, 1'b0};
        tbl[2]  = '{16'h30F2, 11'h18E, 1'b1, 1'b0};
        tbl[3]  = '{16'hB0F3, 11'h18E, 1'b1, 1'b0};
        tbl[4]  = '{16'h30FF, 11'h18F, 1'b0, 1'b1};
        tbl[5]  = '{16'h30F5, 11'h18E, 1'b0, 1'b1};
        tbl[6]  = '{16'h0000, 11'h000, 1'b0, 1'b0};
        tbl[7]  = '{16'hFFFF, 11'h7FF, 1'b0, 1'b0};
        tbl[8]  = '{16'h000F, 11'h001, 1'b0, 1'b0};
        tbl[9]  = '{16'h8117, 11'h400, 1'b0, 1'b0};
        tbl[10] = '{16'h1E11, 11'h0F0, 1'b0, 1'b0};
        tbl[11] = '{16'h20F3, 11'h18E, 1'b1, 1'b0};
        tbl[12] = '{16'hFDFF, 11'h7FF, 1'b1, 1'b0};
        w  = '{16'h000F, 16'h8117, 16'h1E11, 16'hFFFF};
        wd = '{11'h001, 11'h400, 11'h0F0, 11'h7FF};

        in_valid = 1'b1;
        in_code  = 16'h30F3;
        repeat (3) @(posedge clk);
        #1;
        chk("reset out_valid", out_valid, 0);
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("reset in_ready", in_ready, 1);
        chk_counts("reset");
        step();

        for (int i = 0; i < 13; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1;
            in_code  = w[idx < 4 ? idx : 3];
            #1;
            acc = in_ready;
            step();
            if (acc) idx++;
        end
        chk("bp accepted", idx, 2);
        chk("bp in_ready", in_ready, 0);
        chk("bp out_valid", out_valid, 1);
        chk("bp out_data", out_data, wd[0]);
        held = out_data;
        step();
        chk("bp hold", out_data, held);
        out_ready = 1'b1;
        got = 0;
        last = 0;
        gaps = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            in_valid = idx < 4;
            in_code  = w[idx < 4 ? idx : 3];
            #1;
            acc = in_valid && in_ready;
            if (out_valid) begin
                chk($sformatf("bp order%0d", got), out_data, wd[got]);
                if (got > 0 && c != last + 1) gaps++;
                last = c;
                got++;
            end
            step();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        chk("bp delivered", got, 4);
        chk("bp gaps", gaps, 0);
        chk("bp all accepted", idx, 4);
        step();
        chk_counts("bp counts");

        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        exp_sec = 0;
        exp_ded = 0;
        chk_counts("clear");
        for (int i = 0; i < 5; i++) run_vec(tbl[1], $sformatf("sat%0d", i));
        chk("sat value", cnt_sec_n, 3);

        in_valid = 1'b1;
        in_code  = tbl[1].code;
        step();
        in_valid = 1'b0;
        step();
        chk("clr race out_sed", out_sed, 1);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        exp_sec = 0;
        exp_ded = 0;
        chk_counts("clr wins");

`ifdef SECDED_INJECT_EN
        inj_mask = 16'h0004;
        v = tbl[0];
        v.sed = 1'b1;
        run_vec(v, "inject");
        inj_mask = '0;
`else
        v = tbl[3];
        run_vec(v, "plain");
`endif

        in_valid = 1'b1;
        in_code  = tbl[2].code;
        step();
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst out_valid", out_valid, 0);
        exp_sec = 0;
        exp_ded = 0;
        chk_counts("midrst");
        step();
        rst = 1'b0;
        repeat (3) step();
        chk("midrst drained", out_valid, 0);
        chk("midrst in_ready", in_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end

endmodule
